preamble_generator: RTL and testbench
=====================================

PREAMBLE_GENERATOR -- requirements
Module: preamble_generator

Interface
REQ-001 The block SHALL have a single clock `clk_in`, and all logic SHALL be synchronous to its rising edge.
REQ-002 Reset `rst_in` SHALL be synchronous and active-high.
REQ-003 Parameter NUM_STS, default 10: number of 16-sample short training periods emitted.
REQ-004 Parameter LTS_CP_LEN, default 32: long training cyclic-prefix length in samples; legal range 0..64.
REQ-005 Ports (name, direction, width, meaning):
- clk_in, in, 1: clock.
- rst_in, in, 1: synchronous active-high reset.
- start_in, in, 1: single-cycle request to emit one preamble.
- scale_in, in, 2: attenuation, as an arithmetic right-shift count, captured at start.
- busy_out, out, 1: high from accepted start through the final transfer.
- preamble_axis_tvalid, out, 1: AXI-Stream valid.
- preamble_axis_tlast, out, 1: marks the last preamble sample.
- preamble_axis_tdata, out, 32: sample {I[31:16], Q[15:0]}, signed 16-bit each.
- preamble_axis_tready, in, 1: downstream ready.

Function
REQ-006 The block SHALL emit, in order, the following samples, for a total of 16*NUM_STS + LTS_CP_LEN + 128 samples (320 at defaults):
- STS: 16*NUM_STS samples.
- LTS_CP: LTS_CP_LEN samples.
- LTS1: 64 samples.
- LTS2: 64 samples.
REQ-007 FSM states SHALL be IDLE, STS, LTS_CP, LTS1, LTS2.
- IDLE->STS on start_in while idle.
- Each later state SHALL advance only on the handshake (tvalid && tready) of its final sample.
- LTS2 SHALL return to IDLE.
- When LTS_CP_LEN=0, the FSM SHALL skip LTS_CP.
REQ-008 STS sample n SHALL be STS_ROM[n mod 16].
REQ-009 LTS_CP sample k SHALL be LTS_ROM[64-LTS_CP_LEN+k].
REQ-010 LTS1 and LTS2 sample k SHALL be LTS_ROM[k].
REQ-011 ROM contents SHALL be the 802.11a unwindowed time-domain short and long training sequences, quantized as round(x*32768) to signed 16-bit. The following values are fixed:
- STS_ROM[0] = (1507, 1507).
- LTS_ROM[0] = (5112, 0).
- LTS_ROM[32] = (-5112, 0).
REQ-012 Each output component SHALL equal the ROM component arithmetically shifted right by the captured scale_in, with sign preserved and no rounding.
REQ-013 Latency: start_in accepted in cycle N SHALL give tvalid=1 with the first STS sample in cycle N+1.
REQ-014 Once asserted, tvalid, tdata and tlast SHALL hold stable until tready is sampled high.
REQ-015 A new sample SHALL be presented in the cycle after each handshake, so that back-to-back transfers run at one per cycle while tready stays high.
REQ-016 tlast SHALL be 1 only on the final LTS2 sample.
REQ-017 tvalid SHALL fall in the cycle after the tlast handshake.
REQ-018 start_in SHALL be ignored while busy_out=1, including in the cycle of the tlast handshake.
REQ-019 A start in the cycle after the tlast handshake SHALL be accepted.
REQ-020 busy_out SHALL rise in cycle N+1 after an accepted start and fall in the cycle after the tlast handshake.
REQ-021 scale_in changes during a preamble SHALL have no effect on that preamble.
REQ-022 tready held low indefinitely SHALL stall the block without sample loss or duplication.

Reset
REQ-023 On rst_in the block SHALL set state=IDLE, and sample counters and the scale register to 0.
REQ-024 On rst_in the block SHALL drive tvalid=0, tlast=0, tdata=0 and busy_out=0 from the next cycle.
REQ-025 A reset asserted mid-preamble SHALL abort the preamble with no further samples and no tlast.
REQ-026 start_in asserted together with rst_in SHALL be ignored.

Structure
REQ-027 A shared package `preamble_pkg` SHALL hold:
- The state enum type.
- STS_LEN=16 and LTS_LEN=64.
- The STS and LTS ROM constant arrays.
REQ-028 One sub-module `preamble_rom` SHALL provide combinational lookup for both ROMs, with inputs sel (STS or LTS) and a 6-bit index, and a 32-bit sample output.
REQ-029 Output registers SHALL be driven from the ROM lookup with no additional pipeline stage, so that REQ-013 holds.

Verification
REQ-030 Defaults, tready=1, scale_in=0, single start:
- 320 consecutive transfers, starting one cycle after start.
- Sample 0 = 0x05E3_05E3.
- Sample 160 = 0xEC08_0000.
- Sample 192 = 0x13F8_0000.
- tlast only on sample 319.
REQ-031 Random tready (about 50%): the captured stream SHALL be identical to the REQ-030 stream, and tdata/tlast SHALL be stable during every stall.
REQ-032 scale_in=2 at start, changed to 0 mid-frame: sample 0 = 0x0178_0178 and sample 160 = 0xFB02_0000 for the whole frame.
REQ-033 Start pulses during busy and on the tlast-handshake cycle SHALL produce exactly one preamble. Start one cycle after tlast SHALL yield a second full 320-sample preamble.
REQ-034 rst_in at sample 200 with tready=1: tvalid=0 the next cycle, busy_out=0, and no tlast seen. A following start SHALL yield a full preamble.
REQ-035 Structural checks, with LTS_CP_LEN=0 as a separate run:
- STS sample n == sample n+16.
- LTS2 == LTS1.
- CP == last LTS_CP_LEN samples of LTS1.
- LTS_CP_LEN=0 run: 288 samples, with no CP.

Source files
------------

// File: rtl/preamble_pkg.sv
// preamble_pkg: FSM state type, segment lengths and the 802.11a short/long training ROMs
package preamble_pkg;
    typedef enum logic [2:0] {IDLE, STS, LTS_CP, LTS1, LTS2} state_e;
    localparam int STS_LEN = 16;
    localparam int LTS_LEN = 64;
    typedef logic [31:0] sts_rom_t [STS_LEN];
    typedef logic [31:0] lts_rom_t [LTS_LEN];
    // Unwindowed time-domain values in thousandths, I and Q separately
    localparam int STS_MI [STS_LEN] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
    localparam int STS_MQ [STS_LEN] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
    localparam int LTS_MI [LTS_LEN] = '{
        156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
        62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
        -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
        62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
    localparam int LTS_MQ [LTS_LEN] = '{
        0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
        62, -98, -39, -65, -92, -14, -81, 22, 151, 17, 21, 74, -54, -115, -106, -98,
        0, 98, 106, 115, 54, -74, -21, -17, -151, -22, 81, 14, 92, 65, 39, 98,
        -62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};
    // round(m/1000 * 32768), ties cannot occur for integer m
    function automatic logic [15:0] quant(input int m);
        return 16'(m < 0 ? -((-m * 32768 + 500) / 1000) : (m * 32768 + 500) / 1000);
    endfunction
    function automatic sts_rom_t build_sts();
        sts_rom_t r;
        for (int i = 0; i < STS_LEN; i++) r[i] = {quant(STS_MI[i]), quant(STS_MQ[i])};
        return r;
    endfunction
    function automatic lts_rom_t build_lts();
        lts_rom_t r;
        for (int i = 0; i < LTS_LEN; i++) r[i] = {quant(LTS_MI[i]), quant(LTS_MQ[i])};
        return r;
    endfunction
    localparam sts_rom_t STS_ROM = build_sts();
    localparam lts_rom_t LTS_ROM = build_lts();
endpackage

// File: rtl/preamble_rom.sv
// preamble_rom: combinational lookup of the short (sel=0) or long (sel=1) training sample
module preamble_rom
    import preamble_pkg::*;
(
    input  logic        sel,
    input  logic [5:0]  idx,
    output logic [31:0] sample
);
    assign sample = sel ? LTS_ROM[idx] : STS_ROM[idx[3:0]];
endmodule

// File: rtl/preamble_generator.sv
// preamble_generator: streams one scaled 802.11a preamble (STS, LTS cyclic prefix, LTS1, LTS2) per start
// The output register always holds the sample addressed by (state_q, cnt_q).
module preamble_generator
    import preamble_pkg::*;
#(
    parameter int NUM_STS    = 10,
    parameter int LTS_CP_LEN = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [1:0]  scale_in,
    output logic        busy_out,
    output logic        preamble_axis_tvalid,
    output logic        preamble_axis_tlast,
    output logic [31:0] preamble_axis_tdata,
    input  logic        preamble_axis_tready
);
    localparam int CW = 16;
    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last_idx;
    logic [1:0]  scale_q, scale_d;
    logic        valid_q, valid_d, last_q, last_d;
    logic [31:0] data_q, data_d, rom_data;
    logic        rom_sel, hs;
    logic [5:0]  rom_idx;

    preamble_rom u_rom (
        .sel    (rom_sel),
        .idx    (rom_idx),
        .sample (rom_data)
    );

    always_comb begin
        hs       = valid_q && preamble_axis_tready;
        last_idx = state_q == STS ? CW'(STS_LEN * NUM_STS - 1) :
                   state_q == LTS_CP ? CW'(LTS_CP_LEN - 1) : CW'(LTS_LEN - 1);
        state_d  = state_q;
        cnt_d    = cnt_q;
        scale_d  = scale_q;
        if (state_q == IDLE) begin
            if (start_in) begin
                state_d = STS;
                cnt_d   = '0;
                scale_d = scale_in;
            end
        end else if (hs) begin
            cnt_d = cnt_q == last_idx ? '0 : cnt_q + 1'b1;
            if (cnt_q == last_idx)
                state_d = state_q == STS ? (LTS_CP_LEN == 0 ? LTS1 : LTS_CP) :
                          state_q == LTS_CP ? LTS1 : state_q == LTS1 ? LTS2 : IDLE;
        end
        // Look up the sample that will be presented next cycle
        rom_sel = state_d != STS;
        rom_idx = state_d == LTS_CP ? 6'(LTS_LEN - LTS_CP_LEN + int'(cnt_d)) :
                  state_d == STS ? {2'b00, cnt_d[3:0]} : cnt_d[5:0];
        valid_d = state_d != IDLE;
        last_d  = state_d == LTS2 && cnt_d == CW'(LTS_LEN - 1);
        data_d  = valid_d ? {16'($signed(rom_data[31:16]) >>> scale_d),
                             16'($signed(rom_data[15:0]) >>> scale_d)} : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scale_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign busy_out             = valid_q;
    assign preamble_axis_tvalid = valid_q;
    assign preamble_axis_tlast  = last_q;
    assign preamble_axis_tdata  = data_q;
endmodule

// File: tb/tb_preamble_generator.sv
// tb_preamble_generator: scoreboard and table-driven checks of the preamble stream
module tb_preamble_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, ready = 1'b1, start1 = 1'b0, ready1 = 1'b1;
    logic [1:0] scale = 2'd0;
    logic busy, tvalid, tlast, busy1, tvalid1, tlast1;
    logic [31:0] tdata, tdata1;

    preamble_generator u0 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .scale_in(scale), .busy_out(busy),
        .preamble_axis_tvalid(tvalid), .preamble_axis_tlast(tlast),
        .preamble_axis_tdata(tdata), .preamble_axis_tready(ready));

    preamble_generator #(.LTS_CP_LEN(0)) u1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .scale_in(scale), .busy_out(busy1),
        .preamble_axis_tvalid(tvalid1), .preamble_axis_tlast(tlast1),
        .preamble_axis_tdata(tdata1), .preamble_axis_tready(ready1));

    int STS_MI [16] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
    int STS_MQ [16] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
    int LTS_MI [64] = '{
        156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
        62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
        -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
        62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
    int LTS_MQ [64] = '{
        0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
        62, -98, -39, -65, -92, -14, -81, 22, 151, 17, 21, 74, -54, -115, -106, -98,
        0, 98, 106, 115, 54, -74, -21, -17, -151, -22, 81, 14, 92, 65, 39, 98,
        -62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};

    typedef struct { int idx; logic [32:0] exp; } vec_t;
    vec_t va [4];
    vec_t vc [2];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, hs_cnt = 0, tlast_cnt = 0, first_hs_cyc = -1, last_hs_cyc = -1, start_cyc = 0;
    bit rand_rdy = 1'b0, stalled = 1'b0;
    logic [32:0] held;
    logic [32:0] exp_q [$];
    logic [32:0] cap [$];
    logic [32:0] ref_s [$];
    logic [32:0] cap1 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int mi, input int mq, input int sh);
        int iv, qv;
        iv = int'(real'(mi) * 32.768);
        qv = int'(real'(mq) * 32.768);
        return {16'(iv >>> sh), 16'(qv >>> sh)};
    endfunction

    function automatic logic [32:0] frame_sample(input int cp, input int sh, input int n);
        int k;
        k = n;
        if (k < 160) return {1'b0, model(STS_MI[k % 16], STS_MQ[k % 16], sh)};
        k -= 160;
        if (k < cp) return {1'b0, model(LTS_MI[64 - cp + k], LTS_MQ[64 - cp + k], sh)};
        k -= cp;
        return {k == 127, model(LTS_MI[k % 64], LTS_MQ[k % 64], sh)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor for u0, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (stalled) check("stall_hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, held}));
        stalled = tvalid && !ready && !rst;
        held = {tlast, tdata};
        if (tvalid && ready) begin
            cap.push_back({tlast, tdata});
            hs_cnt++;
            if (tlast) tlast_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_sample", 64'({tlast, tdata}), 64'h1_0000_0000_0000);
            else check("sample", 64'({tlast, tdata}), 64'(exp_q.pop_front()));
        end
    end

    initial forever begin
        @(negedge clk);
        if (tvalid1 && ready1) cap1.push_back({tlast1, tdata1});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cap.delete();
        exp_q.delete();
        hs_cnt = 0;
        tlast_cnt = 0;
        first_hs_cyc = -1;
        last_hs_cyc = -1;
    endtask

    task automatic push_frame(input int sh);
        for (int n = 0; n < 320; n++) exp_q.push_back(frame_sample(32, sh, n));
    endtask

    task automatic pulse_start(input logic [1:0] sh);
        scale = sh;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((busy || exp_q.size() != 0) && i < 3000) begin
            tick();
            i++;
        end
        check({name, "_timeout"}, 64'(i >= 3000), 64'h0);
    endtask

    task automatic check_vecs(input string name, input vec_t v);
        if (v.idx < cap.size()) check(name, 64'(cap[v.idx]), 64'(v.exp));
        else check({name, "_missing"}, 64'(cap.size()), 64'(v.idx + 1));
    endtask

    initial begin
        int d;
        va = '{'{0, 33'h0_05E3_05E3}, '{160, 33'h0_EC08_0000}, '{192, 33'h0_13F8_0000}, '{319, 33'h1_FF5C_0F5C}};
        vc = '{'{0, 33'h0_0178_0178}, '{160, 33'h0_FB02_0000}};

        // Reset, including a start held together with reset
        start = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("rst_tvalid", 64'(tvalid), 64'h0);
        check("rst_tlast", 64'(tlast), 64'h0);
        check("rst_tdata", 64'(tdata), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        // Plain frame, tready=1, scale 0
        clear_mon();
        push_frame(0);
        pulse_start(2'd0);
        check("busy_rise", 64'(busy), 64'h1);
        wait_idle("frame_a");
        check("a_count", 64'(hs_cnt), 64'd320);
        check("a_latency", 64'(first_hs_cyc), 64'(start_cyc));
        check("a_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd319);
        check("a_tlast_count", 64'(tlast_cnt), 64'd1);
        for (int i = 0; i < 4; i++) check_vecs("a_vec", va[i]);
        ref_s = cap;
        d = 0;
        for (int n = 0; n < 144; n++) if (ref_s[n] !== ref_s[n + 16]) d++;
        check("sts_periodic", 64'(d), 64'h0);
        d = 0;
        for (int k = 0; k < 64; k++) if (ref_s[192 + k][31:0] !== ref_s[256 + k][31:0]) d++;
        check("lts2_eq_lts1", 64'(d), 64'h0);
        d = 0;
        for (int k = 0; k < 32; k++) if (ref_s[160 + k] !== ref_s[224 + k]) d++;
        check("cp_eq_lts1_tail", 64'(d), 64'h0);

        // Random backpressure must not change the stream
        clear_mon();
        push_frame(0);
        rand_rdy = 1'b1;
        pulse_start(2'd0);
        wait_idle("frame_b");
        rand_rdy = 1'b0;
        tick();
        ready = 1'b1;
        check("b_count", 64'(cap.size()), 64'd320);
        d = 0;
        for (int n = 0; n < 320 && n < cap.size(); n++) if (cap[n] !== ref_s[n]) d++;
        check("b_same_stream", 64'(d), 64'h0);

        // Scale captured at start, later changes ignored
        clear_mon();
        push_frame(2);
        pulse_start(2'd2);
        for (int i = 0; i < 50; i++) tick();
        scale = 2'd0;
        wait_idle("frame_c");
        for (int i = 0; i < 2; i++) check_vecs("c_vec", vc[i]);

        // Starts during busy and on the tlast handshake are ignored; one cycle later is accepted
        clear_mon();
        push_frame(0);
        pulse_start(2'd0);
        d = 0;
        while (!(tvalid && tlast) && d < 1000) begin
            start = (d == 5 || d == 100 || d == 250);
            tick();
            d++;
        end
        check("d_tlast_seen", 64'(d >= 1000), 64'h0);
        start = 1'b1;
        tick();
        check("d_busy_fall", 64'(busy), 64'h0);
        tick();
        start = 1'b0;
        push_frame(0);
        wait_idle("frame_d");
        for (int i = 0; i < 5; i++) tick();
        check("d_count", 64'(hs_cnt), 64'd640);
        check("d_tlast_count", 64'(tlast_cnt), 64'd2);
        check("d_idle_after", 64'(busy), 64'h0);

        // Reset mid-frame aborts it
        clear_mon();
        push_frame(0);
        pulse_start(2'd0);
        d = 0;
        while (hs_cnt < 200 && d < 1000) begin
            tick();
            d++;
        end
        rst = 1'b1;
        tick();
        exp_q.delete();
        @(negedge clk);
        check("e_tvalid_after_rst", 64'(tvalid), 64'h0);
        check("e_busy_after_rst", 64'(busy), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("e_no_tlast", 64'(tlast_cnt), 64'h0);
        clear_mon();
        push_frame(0);
        pulse_start(2'd0);
        wait_idle("frame_e");
        check("e_count", 64'(hs_cnt), 64'd320);
        check("e_tlast_count", 64'(tlast_cnt), 64'd1);

        // LTS_CP_LEN=0 instance
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        d = 0;
        while (busy1 && d < 1000) begin
            tick();
            d++;
        end
        tick();
        check("z_count", 64'(cap1.size()), 64'd288);
        if (cap1.size() == 288) begin
            check("z_sample160", 64'(cap1[160]), 64'h0_13F8_0000);
            check("z_tlast", 64'(cap1[287][32]), 64'h1);
            d = 0;
            for (int n = 0; n < 288; n++) if (cap1[n] !== frame_sample(0, 0, n)) d++;
            check("z_stream", 64'(d), 64'h0);
            d = 0;
            for (int k = 0; k < 64; k++) if (cap1[160 + k][31:0] !== cap1[224 + k][31:0]) d++;
            check("z_lts2_eq_lts1", 64'(d), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
